frame_xform_sequencer: RTL
==========================

# frame_xform_sequencer

Sequences the pixel-by-pixel flip/invert transform of a frame buffer. Walks the source frame in raster order and, per pixel, issues one read and one write through a shared memory port that an external arbiter controls via request/grant. The write goes to the destination frame, at the mirrored column address when flipping, with the colour inverted when inverting. It sits between the control/host logic (start, done) and the frame-buffer memory arbiter.

## Interface
- WIDTH, 320, pixels per row
- HEIGHT, 240, rows per frame
- DW, 8, pixel data width
- AW, 18, memory address width
- SRC_BASE, 0, word address of source frame pixel (0,0)
- DST_BASE, 76800, word address of destination frame pixel (0,0)

- clk  in  1  clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  begin one frame transform; sampled only in IDLE
- mode  in  2  bit0 = invert colour, bit1 = flip horizontally; captured on accepted start
- abort  in  1  cancel the transform in progress
- busy  out  1  high from the cycle after an accepted start until return to IDLE
- done  out  1  one-cycle pulse on normal completion
- mem_req  out  1  port request; held until granted
- mem_we  out  1  1 = write, 0 = read; valid while mem_req
- mem_addr  out  AW  word address; valid while mem_req
- mem_wdata  out  DW  write data; valid while mem_req && mem_we
- mem_gnt  in  1  arbiter grant; the transaction occurs in the cycle mem_req && mem_gnt
- mem_rdata  in  DW  read data, valid exactly 1 cycle after a granted read

## Operation
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, FIN.
- IDLE: if start, capture mode, clear row/col/row_base, go to RD_REQ. Otherwise stay.
- RD_REQ: mem_req=1, mem_we=0, mem_addr = SRC_BASE + row_base + col. On mem_gnt, go to RD_WAIT.
- RD_WAIT: capture pix = mode[0] ? ~mem_rdata : mem_rdata, then go to WR_REQ.
- WR_REQ: mem_req=1, mem_we=1, mem_wdata=pix, mem_addr = DST_BASE + row_base + (mode[1] ? WIDTH-1-col : col).
- On mem_gnt in WR_REQ, advance the pixel position:
  - If col < WIDTH-1: col+1, go to RD_REQ.
  - Else if row < HEIGHT-1: col=0, row+1, row_base += WIDTH, go to RD_REQ.
  - Else (last pixel): go to FIN.
- FIN: done=1 for this one cycle, then go to IDLE.
- Address arithmetic:
  - row_base is a running accumulator; no multiplier.
  - All sums are AW bits wide and truncate modulo 2^AW.
  - col needs ceil(log2 WIDTH) bits and row needs ceil(log2 HEIGHT) bits.
- Precedence of control inputs:
  - abort has priority over everything.
  - In any state other than IDLE, abort=1 forces IDLE on the next cycle, with no done pulse.
  - A transaction granted in the same cycle as abort still counts as issued at the memory.
  - abort in IDLE has no effect.
- start outside IDLE is ignored, and mode is not re-sampled.
- Outputs are combinational from the state and registers; there is no path from mem_gnt to mem_req.

## Timing
- Reset values: state=IDLE, busy=0, done=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0. row, col, row_base, pix and the captured mode are all 0.
- Reset mid-frame returns to IDLE immediately (asynchronous); mem_req drops without waiting for a grant.
- Start: start sampled at edge N puts mem_req high after edge N; the first read can be granted in cycle N+1.
- Per-pixel throughput with immediate grant is 3 cycles (RD_REQ, RD_WAIT, WR_REQ).
- Frame latency with immediate grants is 3·WIDTH·HEIGHT + 1 cycles from the accepted start to the done pulse.
- Each cycle without a grant adds one cycle. mem_addr, mem_we and mem_wdata stay stable while mem_req is waiting.
- busy: high in RD_REQ, RD_WAIT, WR_REQ and FIN; low in IDLE.
- done coincides with the last busy cycle.
- A new start is accepted the cycle after FIN.

## Test plan
- Reset: assert reset_n=0 mid-frame with mem_req=1 -> all outputs read 0 in the same cycle. After release, the block is in IDLE with busy=0 until start.
- Flip + invert (WIDTH=4, HEIGHT=2, SRC_BASE=0, DST_BASE=8, gnt tied 1, mode=3, src=0x00,0x11,…,0x77) -> exactly 16 transactions.
  - Expected writes: addr8←0xCC, addr9←0xDD, addr10←0xEE, addr11←0xFF, addr12←0x88, …, addr15←0xBB.
  - done pulses at cycle 25 after start.
- Copy, same setup with mode=0 -> dst[8+i]=src[i] for all i. Write order is ascending addresses 8..15.
- Grant stalls: mem_gnt driven pseudo-random (about 30% duty), mode=2.
  - Every request is held with stable addr/we/wdata until granted.
  - Final destination contents match a model: row order preserved, columns reversed, no inversion.
- Control corner cases:
  - start pulsed while busy -> ignored, mode unchanged, exactly one done.
  - abort in WR_REQ after the 5th write -> IDLE next cycle, no done, busy=0.
  - A new start afterwards restarts at pixel (0,0).
- Last-pixel wrap: WIDTH=3, HEIGHT=1 -> after the write to DST_BASE+0 (flip), the state goes to FIN with no further requests. Done is 1 for exactly one cycle.

Source files
------------

// File: rtl/frame_xform_sequencer_if.sv
// Shared frame-buffer memory port between the transform sequencer and the arbiter.
// Request is held until granted; read data returns exactly one cycle after a granted read.
interface frame_xform_sequencer_if #(
    parameter int AW = 18,
    parameter int DW = 8
) ();
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_gnt;
    logic [DW-1:0] mem_rdata;

    modport master (output mem_req, mem_we, mem_addr, mem_wdata, input  mem_gnt, mem_rdata);
    modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata, output mem_gnt, mem_rdata);
endinterface

// File: rtl/frame_xform_sequencer.sv
// Walks the source frame in raster order and copies each pixel to the destination frame,
// optionally mirrored horizontally and/or colour-inverted, through one arbitrated memory port.
module frame_xform_sequencer #(
    parameter int WIDTH    = 320,
    parameter int HEIGHT   = 240,
    parameter int DW       = 8,
    parameter int AW       = 18,
    parameter int SRC_BASE = 0,
    parameter int DST_BASE = 76800
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [1:0]              mode,
    input  logic                    abort,
    output logic                    busy,
    output logic                    done,
    frame_xform_sequencer_if.master bus
);
    // Degenerate one-pixel dimensions still need a one-bit counter.
    localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
    localparam logic [AW-1:0] SRC_ADDR = AW'(SRC_BASE);
    localparam logic [AW-1:0] DST_ADDR = AW'(DST_BASE);
    localparam logic [AW-1:0] ROW_STEP = AW'(WIDTH);

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, FIN} state_t;

    state_t        state;
    logic [1:0]    mode_q;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [AW-1:0] row_base;
    logic [DW-1:0] pix;
    logic [CW-1:0] dst_col;

    assign dst_col = mode_q[1] ? (COL_LAST - col) : col;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge value of every other register, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            mode_q   <= 2'b00;
            col      <= '0;
            row      <= '0;
            row_base <= '0;
            pix      <= '0;
        end else if (abort && state != IDLE) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mode_q   <= mode;
                        col      <= '0;
                        row      <= '0;
                        row_base <= '0;
                        state    <= RD_REQ;
                    end
                end
                RD_REQ: begin
                    if (bus.mem_gnt) state <= RD_WAIT;
                end
                RD_WAIT: begin
                    pix   <= mode_q[0] ? ~bus.mem_rdata : bus.mem_rdata;
                    state <= WR_REQ;
                end
                WR_REQ: begin
                    if (bus.mem_gnt) begin
                        if (col != COL_LAST) begin
                            col   <= col + 1'b1;
                            state <= RD_REQ;
                        end else if (row != ROW_LAST) begin
                            col      <= '0;
                            row      <= row + 1'b1;
                            row_base <= row_base + ROW_STEP;
                            state    <= RD_REQ;
                        end else begin
                            state <= FIN;
                        end
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode only state and registers, so the grant never feeds back into the request.
    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        busy          = (state != IDLE);
        done          = (state == FIN);
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        case (state)
            RD_REQ: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = SRC_ADDR + row_base + AW'(col);
            end
            WR_REQ: begin
                bus.mem_req   = 1'b1;
                bus.mem_we    = 1'b1;
                bus.mem_addr  = DST_ADDR + row_base + AW'(dst_col);
                bus.mem_wdata = pix;
            end
            default: ;
        endcase
    end
endmodule
